serial_compare_ctrl: RTL and testbench
======================================

# serial_compare_ctrl

Bit-serial magnitude comparator controller. Accepts two WIDTH-bit operands on a start pulse and streams them MSB-first into the team's 1-bit `compare` stage (via `cmp_a`/`cmp_b`/`cmp_en`). It consumes that stage's `AltB`/`AbtB`/`AeqB` flags each cycle and stops at the first differing bit. It then presents a registered WIDTH-bit compare result with a done pulse. It sits directly around the 1-bit comparator: it is the stage upstream of its inputs and downstream of its outputs.

## Interface
- `WIDTH`, default 8: operand width in bits, ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request. Accepted only in IDLE or DONE.
- `op_a` in WIDTH: operand A. Sampled on the accepting edge.
- `op_b` in WIDTH: operand B. Sampled on the accepting edge.
- `busy` out 1: high while in SHIFT.
- `done` out 1: one-cycle pulse; results valid.
- `a_lt_b` out 1: registered result, A < B.
- `a_gt_b` out 1: registered result, A > B.
- `a_eq_b` out 1: registered result, A == B.
- `err` out 1: comparator flags were not one-hot during a SHIFT cycle. Sticky until the next accepted start.
- `cmp_a` out 1: current bit of A sent to the comparator.
- `cmp_b` out 1: current bit of B sent to the comparator.
- `cmp_en` out 1: comparator enable.
- `cmp_lt` in 1: from comparator `AltB` (combinational, same cycle).
- `cmp_gt` in 1: from comparator `AbtB`.
- `cmp_eq` in 1: from comparator `AeqB`.

## Operation
- States: IDLE, SHIFT, DONE.
- Accepting edge (IDLE or DONE, `start`=1):
  - Load shift registers `sa`←`op_a`, `sb`←`op_b`.
  - Set bit counter to WIDTH-1.
  - Clear all result flags and `err`.
  - Go to SHIFT.
- SHIFT, combinational outputs: `cmp_a`=`sa[WIDTH-1]`, `cmp_b`=`sb[WIDTH-1]`, `cmp_en`=1.
- SHIFT, each edge:
  - If flags are not exactly one-hot: set `err`, finish with `a_eq_b`=1, go to DONE.
  - Else if `cmp_lt`: set `a_lt_b`, go to DONE.
  - Else if `cmp_gt`: set `a_gt_b`, go to DONE.
  - Else if counter==0: set `a_eq_b`, go to DONE.
  - Otherwise: shift `sa`/`sb` left by 1, decrement the counter.
- DONE:
  - `done`=1 for this one cycle.
  - Without `start`, go to IDLE.
  - With `start`, accept the new operands (back-to-back start).
- Outside SHIFT: `cmp_en`=`cmp_a`=`cmp_b`=0.
- Results hold from DONE until the next accepted start.
- `start` during SHIFT is ignored and is not queued.
- Result flags are one-hot after a completed compare, and all zero before the first compare.
- Counter width is $clog2(WIDTH). It never wraps, because exit occurs at 0.

## Timing
- Reset (async assert, sync release):
  - State returns to IDLE.
  - `busy`, `done`, `a_lt_b`, `a_gt_b`, `a_eq_b`, `err`, `cmp_en`, `cmp_a`, `cmp_b` are all 0.
  - Shift registers and counter are 0.
- Reset asserted mid-SHIFT aborts immediately. No `done` is issued.
- Latency: let m be the number of bits examined (1 … WIDTH).
  - m = index from the MSB of the first differing bit, plus 1.
  - m = WIDTH if the operands are equal.
- Start accepted at edge 0:
  - `busy` is high for cycles 1…m.
  - `done` is high in cycle m+1 only.
  - Results are valid from cycle m+1.
- Throughput with back-to-back starts: one compare per m+1 cycles.
- Comparator flags are sampled on the same edge as the bits they refer to. The comparator is purely combinational, so there are no extra pipeline stages.

## Structure
- Package `serial_cmp_pkg`:
  - `typedef enum logic [1:0] {IDLE, SHIFT, DONE} scmp_state_t`
  - `typedef enum logic [1:0] {RES_NONE, RES_LT, RES_GT, RES_EQ} scmp_res_t`
  - Output flags are decoded from `scmp_res_t`.
- No internal sub-module. The existing 1-bit `compare` is instantiated alongside in the parent or test wrapper, with `cmp_*` wired to its ports.

## Test plan
WIDTH=8 throughout, with the real `compare` attached unless stated otherwise.

1. Reset: hold `rst_n`=0, toggle inputs → all outputs 0. Release → still 0, state IDLE.
2. `op_a`=0xA5, `op_b`=0xA5, start → `busy` for 8 cycles, then `done` in cycle 9 with `a_eq_b`=1, `a_lt_b`=`a_gt_b`=0, `err`=0.
3. `op_a`=0x80, `op_b`=0x7F → `done` in cycle 2, `a_gt_b`=1. `op_a`=0x3C, `op_b`=0x3D → `done` in cycle 9, `a_lt_b`=1.
4. Back-to-back and ignored starts:
   - Start 0x10 vs 0x20; pulse `start` again with 0xFF/0x00 during `busy` → ignored, `a_lt_b`=1 at `done` (cycle 4).
   - Start in the `done` cycle with 0xFF/0x00 → `a_gt_b`=1 two cycles later.
5. Async reset: `rst_n` low during cycle 3 of an 8-bit equal compare → outputs 0 immediately, no `done` pulse. A fresh start afterwards completes normally.
6. Stub comparator drives `cmp_lt`=`cmp_gt`=1 → `err`=1 and `a_eq_b`=1 at `done` in cycle 2. The next start clears `err`.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator controller:
// FSM states, compare result encoding and a flag sanity helper.
package serial_cmp_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} scmp_state_t;

  typedef enum logic [1:0] {RES_NONE, RES_LT, RES_GT, RES_EQ} scmp_res_t;

  localparam int DEFAULT_WIDTH = 8;

  // The 1-bit comparator must assert exactly one of its three flags.
  function automatic logic flags_onehot(input logic lt, input logic gt, input logic eq);
    return ({lt, gt, eq} == 3'b100) ||
           ({lt, gt, eq} == 3'b010) ||
           ({lt, gt, eq} == 3'b001);
  endfunction

endpackage

// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude comparator controller: streams two operands MSB-first
// into an external 1-bit compare stage and stops at the first differing bit.
module serial_compare_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             err,
  output logic             cmp_a,
  output logic             cmp_b,
  output logic             cmp_en,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  input  logic             cmp_eq
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  scmp_state_t      r_state;
  scmp_res_t        r_res;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic             r_err;

  logic w_accept;
  logic w_flags_ok;

  // A new request may land in DONE as well, giving back-to-back compares.
  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_flags_ok = flags_onehot(cmp_lt, cmp_gt, cmp_eq);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_res   <= RES_NONE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_sa    <= op_a;
      r_sb    <= op_b;
      r_cnt   <= CNT_LOAD;
      r_res   <= RES_NONE;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        SHIFT: begin
          if (!w_flags_ok) begin
            // Untrustworthy flags: terminate with a defined one-hot result.
            r_err   <= 1'b1;
            r_res   <= RES_EQ;
            r_state <= DONE;
          end else if (cmp_lt) begin
            r_res   <= RES_LT;
            r_state <= DONE;
          end else if (cmp_gt) begin
            r_res   <= RES_GT;
            r_state <= DONE;
          end else if (r_cnt == '0) begin
            r_res   <= RES_EQ;
            r_state <= DONE;
          end else begin
            r_sa  <= {r_sa[WIDTH-2:0], 1'b0};
            r_sb  <= {r_sb[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    cmp_en = 1'b0;
    cmp_a  = 1'b0;
    cmp_b  = 1'b0;
    if (r_state == SHIFT) begin
      cmp_en = 1'b1;
      cmp_a  = r_sa[WIDTH-1];
      cmp_b  = r_sb[WIDTH-1];
    end
  end

  assign busy   = (r_state == SHIFT);
  assign done   = (r_state == DONE);
  assign a_lt_b = (r_res == RES_LT);
  assign a_gt_b = (r_res == RES_GT);
  assign a_eq_b = (r_res == RES_EQ);
  assign err    = r_err;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Self-checking bench for serial_compare_ctrl with a behavioural 1-bit
// comparator attached (switchable to a faulty stub that asserts lt and gt).
module tb_serial_compare_ctrl;

  localparam int W = 8;
  localparam logic [2:0] F_LT = 3'b100;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_EQ = 3'b001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, a_lt_b, a_gt_b, a_eq_b, err;
  logic         cmp_a, cmp_b, cmp_en;
  logic         cmp_lt, cmp_gt, cmp_eq;
  logic         stub;

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .a_lt_b(a_lt_b), .a_gt_b(a_gt_b),
    .a_eq_b(a_eq_b), .err(err), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_en(cmp_en), .cmp_lt(cmp_lt), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the 1-bit compare stage.
  always_comb begin
    cmp_lt = cmp_en & ~cmp_a &  cmp_b;
    cmp_gt = cmp_en &  cmp_a & ~cmp_b;
    cmp_eq = cmp_en & (cmp_a == cmp_b);
    if (stub) begin
      cmp_lt = 1'b1;
      cmp_gt = 1'b1;
      cmp_eq = 1'b0;
    end
  end

  typedef struct {
    logic [2:0] flags;
    int         m;
    logic       err;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   flags;
    int           m;
  } vec_t;

  exp_t sb_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   cur_n  = 0;
  int   bad_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] all_outs();
    return {busy, done, a_lt_b, a_gt_b, a_eq_b, err, cmp_en, cmp_a, cmp_b};
  endfunction

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [2:0] f, output int m);
    m = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        m = W - i;
        break;
      end
    end
    f = (a < b) ? F_LT : (a > b) ? F_GT : F_EQ;
  endfunction

  // Drive a start at a falling edge; returns sampling in cycle 1 after acceptance.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] f, input int m, input logic e, input bit push);
    exp_t x;
    if (push) begin
      x.flags = f; x.m = m; x.err = e;
      sb_q.push_back(x);
    end
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cur_n = 1;
  endtask

  // Waits (bounded) for done, pops the scoreboard and compares.
  task automatic finish_wait(input string name, input bit hold_check);
    exp_t x;
    bad_busy = 0;
    while (!done && cur_n < 40) begin
      if (!busy) bad_busy++;
      @(negedge clk);
      cur_n++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, cur_n);
      return;
    end
    if (sb_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s_scoreboard: done with empty expectation queue", name);
      return;
    end
    x = sb_q.pop_front();
    check({name, "_flags"}, {a_lt_b, a_gt_b, a_eq_b}, x.flags);
    check({name, "_done_cycle"}, cur_n, x.m + 1);
    check({name, "_err"}, err, x.err);
    check({name, "_busy_gap"}, bad_busy, 0);
    check({name, "_busy_at_done"}, busy, 1'b0);
    if (hold_check) begin
      @(negedge clk);
      check({name, "_hold"}, {done, busy, cmp_en, a_lt_b, a_gt_b, a_eq_b, err},
            {3'b000, x.flags, x.err});
    end
  endtask

  vec_t vecs[9];

  initial begin
    logic [2:0] mf;
    int         mm;
    logic [W-1:0] ra, rb;
    int         done_seen;

    vecs[0] = '{8'hA5, 8'hA5, F_EQ, 8};
    vecs[1] = '{8'h80, 8'h7F, F_GT, 1};
    vecs[2] = '{8'h3C, 8'h3D, F_LT, 8};
    vecs[3] = '{8'h10, 8'h20, F_LT, 3};
    vecs[4] = '{8'hFF, 8'h00, F_GT, 1};
    vecs[5] = '{8'h00, 8'h01, F_LT, 8};
    vecs[6] = '{8'h00, 8'h00, F_EQ, 8};
    vecs[7] = '{8'h7F, 8'hFF, F_LT, 1};
    vecs[8] = '{8'h55, 8'h54, F_GT, 8};

    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; stub = 1'b0;

    // Reset held while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = ~start; op_a = 8'($urandom); op_b = 8'($urandom);
      #1 check("reset_held_outs", all_outs(), 9'h0);
    end
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_released_outs", all_outs(), 9'h0);

    // Equal operands: check the comparator drive in the first SHIFT cycle.
    launch(8'hA5, 8'hA5, F_EQ, 8, 1'b0, 1'b1);
    check("shift_cmp_drive", {cmp_en, cmp_a, cmp_b}, 3'b111);
    finish_wait("eq_a5", 1'b1);

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].flags, vecs[i].m, 1'b0, 1'b1);
      finish_wait($sformatf("vec%0d", i), 1'b1);
    end

    // Random operands against the reference model.
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = (i % 2 == 0) ? (ra ^ 8'(1 << $urandom_range(0, W - 1))) : 8'($urandom);
      model(ra, rb, mf, mm);
      launch(ra, rb, mf, mm, 1'b0, 1'b1);
      finish_wait($sformatf("rand%0d", i), 1'b1);
    end

    // Start during SHIFT is ignored; start in the DONE cycle is accepted.
    launch(8'h10, 8'h20, F_LT, 3, 1'b0, 1'b1);
    op_a = 8'hFF; op_b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cur_n = 2;
    finish_wait("ignored_start", 1'b0);
    sb_q.push_back('{F_GT, 1, 1'b0});
    op_a = 8'hFF; op_b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cur_n = 1;
    finish_wait("back_to_back", 1'b1);

    // Asynchronous reset in cycle 3 of an equal compare.
    launch(8'hA5, 8'hA5, F_EQ, 8, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1 check("abort_outs_immediate", all_outs(), 9'h0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    launch(8'h3C, 8'h3D, F_LT, 8, 1'b0, 1'b1);
    finish_wait("after_abort", 1'b1);

    // Faulty comparator asserting lt and gt together.
    stub = 1'b1;
    launch(8'h12, 8'h34, F_EQ, 1, 1'b1, 1'b1);
    finish_wait("stub_err", 1'b1);
    stub = 1'b0;
    launch(8'h12, 8'h34, F_LT, 3, 1'b0, 1'b1);
    check("err_cleared_on_start", err, 1'b0);
    finish_wait("after_err", 1'b1);

    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
